// File: rtl/reg_bank_pkg.sv
// Shared widths, command/endreg encodings and FSM state type for the
// register-bank master.
package reg_bank_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ_A  = 2'b01,
        OP_READ_B  = 2'b10,
        OP_READ_AB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MODE_BOTH = 2'b00,
        MODE_LO   = 2'b01,
        MODE_HI   = 2'b10,
        MODE_SWAP = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        VERIFY,
        CAPTURE,
        RESP
    } state_e;

endpackage

// File: rtl/reg_bank_master.sv
// Command/response master driving a two-port register bank.
// Define REG_BANK_MASTER_RDBACK_EN to read back every write and report mismatches.
module reg_bank_master
    import reg_bank_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [ADDR_W-1:0] cmd_waddr,
    input  logic [1:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_raddrA,
    input  logic [ADDR_W-1:0] cmd_raddrB,
    input  logic              cmd_cnstA,
    input  logic              cmd_cnstB,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dataA,
    output logic [DATA_W-1:0] rsp_dataB,
    output logic              rsp_err,
    output logic              regwen,
    output logic [DATA_W-1:0] inA,
    output logic [ADDR_W-1:0] selwreg,
    output logic [1:0]        endreg,
    output logic [ADDR_W-1:0] seloutA,
    output logic [ADDR_W-1:0] seloutB,
    output logic              cnstA,
    output logic              cnstB,
    output logic              enrregA,
    output logic              enrregB,
    input  logic [DATA_W-1:0] outA,
    input  logic [DATA_W-1:0] outB
);

    state_e              state_q;
    logic                regwen_q;
    logic [DATA_W-1:0]   inA_q;
    logic [ADDR_W-1:0]   selwreg_q;
    logic [1:0]          endreg_q;
    logic [ADDR_W-1:0]   seloutA_q;
    logic [ADDR_W-1:0]   seloutB_q;
    logic                cnstA_q;
    logic                cnstB_q;
    logic                enrregA_q;
    logic                enrregB_q;
    logic                rdA_q;
    logic                rdB_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_dataA_q;
    logic [DATA_W-1:0]   rsp_dataB_q;
`ifdef REG_BANK_MASTER_RDBACK_EN
    logic                is_wr_q;
    logic                rsp_err_q;
`endif

    // The bank-side output registers double as the latched command:
    // inA/endreg keep the write data and mode for the readback compare.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            regwen_q    <= 1'b0;
            inA_q       <= '0;
            selwreg_q   <= '0;
            endreg_q    <= '0;
            seloutA_q   <= '0;
            seloutB_q   <= '0;
            cnstA_q     <= 1'b0;
            cnstB_q     <= 1'b0;
            enrregA_q   <= 1'b0;
            enrregB_q   <= 1'b0;
            rdA_q       <= 1'b0;
            rdB_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dataA_q <= '0;
            rsp_dataB_q <= '0;
`ifdef REG_BANK_MASTER_RDBACK_EN
            is_wr_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            regwen_q  <= 1'b0;
            enrregA_q <= 1'b0;
            enrregB_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_WRITE) begin
                            state_q   <= WRITE;
                            regwen_q  <= 1'b1;
                            inA_q     <= cmd_wdata;
                            selwreg_q <= cmd_waddr;
                            endreg_q  <= cmd_mode;
                        end else begin
                            state_q   <= READ;
                            enrregA_q <= cmd_op[0];
                            enrregB_q <= cmd_op[1];
                            rdA_q     <= cmd_op[0];
                            rdB_q     <= cmd_op[1];
                            seloutA_q <= cmd_raddrA;
                            seloutB_q <= cmd_raddrB;
                            cnstA_q   <= cmd_cnstA;
                            cnstB_q   <= cmd_cnstB;
                        end
`ifdef REG_BANK_MASTER_RDBACK_EN
                        is_wr_q <= (cmd_op == OP_WRITE);
`endif
                    end
                end
                WRITE: begin
`ifdef REG_BANK_MASTER_RDBACK_EN
                    state_q   <= VERIFY;
                    enrregA_q <= 1'b1;
                    seloutA_q <= selwreg_q;
                    cnstA_q   <= 1'b0;
                    rdA_q     <= 1'b1;
                    rdB_q     <= 1'b0;
`else
                    state_q <= IDLE;
`endif
                end
                READ, VERIFY: state_q <= CAPTURE;
                CAPTURE: begin
                    if (rdA_q) rsp_dataA_q <= outA;
                    if (rdB_q) rsp_dataB_q <= outB;
`ifdef REG_BANK_MASTER_RDBACK_EN
                    rsp_err_q <= is_wr_q && (endreg_q == MODE_BOTH) && (outA != inA_q);
`endif
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by reset so every output reads 0 while reset is held, yet a
    // command can be taken on the very first edge after release.
    assign cmd_ready = (state_q == IDLE) && !reset;

    assign rsp_valid = rsp_valid_q;
    assign rsp_dataA = rsp_dataA_q;
    assign rsp_dataB = rsp_dataB_q;
`ifdef REG_BANK_MASTER_RDBACK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif
    assign regwen    = regwen_q;
    assign inA       = inA_q;
    assign selwreg   = selwreg_q;
    assign endreg    = endreg_q;
    assign seloutA   = seloutA_q;
    assign seloutB   = seloutB_q;
    assign cnstA     = cnstA_q;
    assign cnstB     = cnstB_q;
    assign enrregA   = enrregA_q;
    assign enrregB   = enrregB_q;

endmodule

// File: tb/tb_reg_bank_master.sv
// Directed bench for reg_bank_master with a behavioural register bank.
// Honours REG_BANK_MASTER_RDBACK_EN when defined for the build.
module tb_reg_bank_master;

    localparam logic [63:0] CONST_A = 64'hC0C0_FFEE_0000_1234;
    localparam logic [63:0] CONST_B = 64'h5A5A_A5A5_0F0F_F0F0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [63:0] cmd_wdata = '0;
    logic [3:0]  cmd_waddr = '0;
    logic [1:0]  cmd_mode = '0;
    logic [3:0]  cmd_raddrA = '0;
    logic [3:0]  cmd_raddrB = '0;
    logic        cmd_cnstA = 1'b0;
    logic        cmd_cnstB = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_dataA;
    logic [63:0] rsp_dataB;
    logic        rsp_err;
    logic        regwen;
    logic [63:0] inA;
    logic [3:0]  selwreg;
    logic [1:0]  endreg;
    logic [3:0]  seloutA;
    logic [3:0]  seloutB;
    logic        cnstA;
    logic        cnstB;
    logic        enrregA;
    logic        enrregB;
    logic [63:0] outA = '0;
    logic [63:0] outB = '0;

    logic [63:0] bank [16];
    logic [63:0] flip = '0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] lastA = '0;
    logic [63:0] lastB = '0;

    always #5 clock = ~clock;

    reg_bank_master dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wdata(cmd_wdata), .cmd_waddr(cmd_waddr), .cmd_mode(cmd_mode),
        .cmd_raddrA(cmd_raddrA), .cmd_raddrB(cmd_raddrB),
        .cmd_cnstA(cmd_cnstA), .cmd_cnstB(cmd_cnstB),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dataA(rsp_dataA), .rsp_dataB(rsp_dataB), .rsp_err(rsp_err),
        .regwen(regwen), .inA(inA), .selwreg(selwreg), .endreg(endreg),
        .seloutA(seloutA), .seloutB(seloutB), .cnstA(cnstA), .cnstB(cnstB),
        .enrregA(enrregA), .enrregB(enrregB), .outA(outA), .outB(outB)
    );

    // Bank: 01 writes the low half, 10 the high half, 11 stores halves swapped.
    always @(posedge clock) begin
        if (regwen) begin
            case (endreg)
                2'b00: bank[selwreg] <= inA;
                2'b01: bank[selwreg][31:0] <= inA[31:0];
                2'b10: bank[selwreg][63:32] <= inA[63:32];
                default: bank[selwreg] <= {inA[31:0], inA[63:32]};
            endcase
        end
        if (enrregA) outA <= (cnstA ? CONST_A : bank[seloutA]) ^ flip;
        if (enrregB) outB <= cnstB ? CONST_B : bank[seloutB];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] wa, input logic [63:0] wd,
                         input logic [1:0] md, input logic [3:0] ra, input logic [3:0] rb,
                         input logic ca, input logic cb);
        @(negedge clock);
        cmd_op = op; cmd_waddr = wa; cmd_wdata = wd; cmd_mode = md;
        cmd_raddrA = ra; cmd_raddrB = rb; cmd_cnstA = ca; cmd_cnstB = cb;
        cmd_valid = 1'b1;
        for (int n = 0; n < 40 && !cmd_ready; n++) @(negedge clock);
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL accept: cmd_ready never rose");
            cmd_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1 cmd_valid = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the first negedge where rsp_valid is seen.
    task automatic wait_rsp(input string name);
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clock);
        if (!rsp_valid) begin
            n_checks++;
            $display("FAIL %s: rsp_valid timeout, got 0 expected 1", name);
        end
    endtask

    task automatic consume();
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  wa;
        logic [63:0] wd;
        logic [1:0]  md;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        ca;
        logic        cb;
        logic [63:0] ea;
        logic [63:0] eb;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int lat;
        logic saw;
        for (int i = 0; i < 16; i++) bank[i] = '0;

        tbl[0] = '{2'b00, 4'hA, 64'd24, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 64'd24, 64'd0};
        tbl[1] = '{2'b00, 4'hB, 64'd25, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 64'd25, 64'd0};
        tbl[2] = '{2'b11, 4'h0, 64'd0, 2'b00, 4'hA, 4'hB, 1'b0, 1'b0, 64'd24, 64'd25};
        tbl[3] = '{2'b00, 4'h3, 64'h0123_4567_89AB_CDEF, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0,
                   64'h0123_4567_89AB_CDEF, 64'd0};
        tbl[4] = '{2'b01, 4'h0, 64'd0, 2'b00, 4'h3, 4'h0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0};
        tbl[5] = '{2'b10, 4'h0, 64'd0, 2'b00, 4'h0, 4'hA, 1'b0, 1'b0, 64'd0, 64'd24};
        tbl[6] = '{2'b01, 4'h0, 64'd0, 2'b00, 4'h2, 4'h0, 1'b1, 1'b0, CONST_A, 64'd0};
        tbl[7] = '{2'b10, 4'h0, 64'd0, 2'b00, 4'h0, 4'h2, 1'b0, 1'b1, 64'd0, CONST_B};
        tbl[8] = '{2'b00, 4'h5, 64'hAAAA_BBBB_CCCC_DDDD, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0,
                   64'hAAAA_BBBB_0000_0000, 64'd0};
        tbl[9] = '{2'b01, 4'h0, 64'd0, 2'b00, 4'h5, 4'h0, 1'b0, 1'b0, 64'hAAAA_BBBB_0000_0000, 64'd0};

        // Reset state
        #2;
        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset regwen", regwen, 0);
        chk("reset inA", inA, 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        #1 chk("post-reset cmd_ready", cmd_ready, 1);

        // rsp_ready with no response pending has no effect
        rsp_ready = 1'b1;
        @(negedge clock); @(negedge clock);
        chk("stray rsp_ready rsp_valid", rsp_valid, 0);
        chk("stray rsp_ready cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].op, tbl[i].wa, tbl[i].wd, tbl[i].md, tbl[i].ra, tbl[i].rb,
                  tbl[i].ca, tbl[i].cb);
            @(negedge clock);
            if (tbl[i].op == 2'b00) begin
                chk($sformatf("row%0d regwen", i), regwen, 1);
                chk($sformatf("row%0d selwreg", i), selwreg, tbl[i].wa);
                chk($sformatf("row%0d inA", i), inA, tbl[i].wd);
                chk($sformatf("row%0d endreg", i), endreg, tbl[i].md);
                chk($sformatf("row%0d enrregA in write", i), enrregA, 0);
                @(negedge clock);
                chk($sformatf("row%0d regwen pulse end", i), regwen, 0);
`ifdef REG_BANK_MASTER_RDBACK_EN
                chk($sformatf("row%0d verify enrregA", i), enrregA, 1);
                chk($sformatf("row%0d verify seloutA", i), seloutA, tbl[i].wa);
                wait_rsp($sformatf("row%0d", i));
                chk($sformatf("row%0d readback", i), rsp_dataA, tbl[i].ea);
                chk($sformatf("row%0d rsp_err", i), rsp_err, 0);
                lastA = tbl[i].ea;
                consume();
`else
                chk($sformatf("row%0d no response", i), rsp_valid, 0);
                chk($sformatf("row%0d back to idle", i), cmd_ready, 1);
`endif
            end else begin
                chk($sformatf("row%0d enrregA", i), enrregA, tbl[i].op[0]);
                chk($sformatf("row%0d enrregB", i), enrregB, tbl[i].op[1]);
                chk($sformatf("row%0d cnstA", i), cnstA, tbl[i].ca);
                chk($sformatf("row%0d cnstB", i), cnstB, tbl[i].cb);
                chk($sformatf("row%0d regwen in read", i), regwen, 0);
                wait_rsp($sformatf("row%0d", i));
                if (tbl[i].op[0]) lastA = tbl[i].ea;
                if (tbl[i].op[1]) lastB = tbl[i].eb;
                chk($sformatf("row%0d rsp_dataA", i), rsp_dataA, lastA);
                chk($sformatf("row%0d rsp_dataB", i), rsp_dataB, lastB);
                chk($sformatf("row%0d rsp_err", i), rsp_err, 0);
                consume();
            end
        end

        // Read latency: rsp_valid on the third cycle after the accept edge
        issue(2'b11, 4'h0, 64'd0, 2'b00, 4'hA, 4'hB, 1'b0, 1'b0);
        lat = 0;
        for (int n = 0; n < 20 && !rsp_valid; n++) begin
            @(negedge clock);
            lat++;
        end
        chk("read latency", 64'(lat), 64'd3);
        lastA = 64'd24; lastB = 64'd25;
        consume();

        // Backpressure with a write pending on the command side
        issue(2'b01, 4'h0, 64'd0, 2'b00, 4'hB, 4'h0, 1'b0, 1'b0);
        @(negedge clock);
        wait_rsp("backpressure");
        lastA = 64'd25;
        cmd_op = 2'b00; cmd_waddr = 4'h7; cmd_wdata = 64'h77; cmd_mode = 2'b00;
        cmd_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            chk($sformatf("hold%0d rsp_valid", n), rsp_valid, 1);
            chk($sformatf("hold%0d rsp_dataA", n), rsp_dataA, lastA);
            chk($sformatf("hold%0d rsp_dataB", n), rsp_dataB, lastB);
            chk($sformatf("hold%0d cmd_ready", n), cmd_ready, 0);
            chk($sformatf("hold%0d regwen", n), regwen, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        @(negedge clock);
        chk("pending cmd_ready", cmd_ready, 1);
        chk("pending rsp_valid", rsp_valid, 0);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        chk("pending write regwen", regwen, 1);
        chk("pending write selwreg", selwreg, 7);
`ifdef REG_BANK_MASTER_RDBACK_EN
        wait_rsp("pending write");
        chk("pending write readback", rsp_dataA, 64'h77);
        lastA = 64'h77;
        consume();
`endif

        // Reset asserted during CAPTURE drops the read
        issue(2'b11, 4'h0, 64'd0, 2'b00, 4'hA, 4'hB, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid reset rsp_valid", rsp_valid, 0);
        chk("mid reset rsp_dataA", rsp_dataA, 0);
        chk("mid reset seloutA", seloutA, 0);
        chk("mid reset seloutB", seloutB, 0);
        chk("mid reset cmd_ready", cmd_ready, 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            if (rsp_valid) saw = 1'b1;
        end
        chk("no response after reset", saw, 0);
        issue(2'b11, 4'h0, 64'd0, 2'b00, 4'hA, 4'hB, 1'b0, 1'b0);
        @(negedge clock);
        wait_rsp("after reset");
        chk("after reset rsp_dataA", rsp_dataA, 64'd24);
        chk("after reset rsp_dataB", rsp_dataB, 64'd25);
        consume();

`ifdef REG_BANK_MASTER_RDBACK_EN
        // Swapped write reads back differently but mode 11 never flags an error
        issue(2'b00, 4'h4, 64'h1111_2222_3333_4444, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clock);
        wait_rsp("swap write");
        chk("swap readback", rsp_dataA, 64'h3333_4444_1111_2222);
        chk("swap rsp_err", rsp_err, 0);
        consume();
        // A corrupted readback of a full write must be flagged
        flip = 64'h0000_0000_0000_0100;
        issue(2'b00, 4'h6, 64'hDEAD_BEEF_0000_0001, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clock);
        wait_rsp("corrupt write");
        chk("corrupt readback", rsp_dataA, 64'hDEAD_BEEF_0000_0101);
        chk("corrupt rsp_err", rsp_err, 1);
        consume();
        flip = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_master.md
REG_BANK_MASTER -- requirements
Module: reg_bank_master

Interface
REQ-001 clock  in  1  master clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 cmd_valid  in  1  command request; cmd_ready  out  1  command accepted when both high at posedge.
REQ-004 cmd_op  in  2  00 write, 01 read A, 10 read B, 11 read A and B.
REQ-005 cmd_wdata  in  64  write data; cmd_waddr  in  4  write register index; cmd_mode  in  2  endreg code for the write.
REQ-006 cmd_raddrA / cmd_raddrB  in  4 each  read indexes; cmd_cnstA / cmd_cnstB  in  1 each  constant-select for reads.
REQ-007 rsp_valid  out  1  response available; rsp_ready  in  1  response consumed when both high at posedge.
REQ-008 rsp_dataA / rsp_dataB  out  64 each  captured bank outputs; rsp_err  out  1  readback mismatch (REQ-026).
REQ-009 Bank side outputs: regwen 1, inA 64, selwreg 4, endreg 2, seloutA 4, seloutB 4, cnstA 1, cnstB 1, enrregA 1, enrregB 1; bank side inputs: outA 64, outB 64.

Function
REQ-010 States: IDLE, WRITE, READ, CAPTURE, RESP (VERIFY only with REQ-025).
REQ-011 cmd_ready SHALL be 1 only in IDLE; on accept, latch all cmd_* fields; op 00 -> WRITE, else -> READ.
REQ-012 WRITE lasts exactly one cycle: regwen=1, inA/selwreg/endreg from latched command; next state IDLE.
REQ-013 READ lasts exactly one cycle: enrregA=1 if op bit0, enrregB=1 if op bit1, seloutA/seloutB/cnstA/cnstB from latch; next CAPTURE.
REQ-014 CAPTURE lasts one cycle: at its closing posedge sample outA into rsp_dataA if enrregA was pulsed, outB into rsp_dataB if enrregB was pulsed; non-read field keeps previous value; next RESP.
REQ-015 RESP: rsp_valid=1; on rsp_ready -> IDLE; while rsp_valid and !rsp_ready all rsp_* SHALL hold stable.
REQ-016 All bank-side outputs SHALL be registered; regwen, enrregA, enrregB SHALL be 0 outside WRITE/READ; select/data fields hold last driven value.
REQ-017 Latency: write accept to regwen high = 1 cycle; read accept to rsp_valid = 3 cycles; minimum write period 2 cycles, read period 4 cycles.
REQ-018 cmd_valid while not IDLE SHALL be ignored (no queuing); command remains pending until accepted.
REQ-019 Never assert regwen and enrregA/enrregB in the same cycle.
REQ-020 rsp_ready without rsp_valid SHALL have no effect.

Reset
REQ-021 On reset assertion, asynchronously: state IDLE, all outputs 0, latched command discarded.
REQ-022 Reset mid-transaction (any state) SHALL drop the transaction with no response; first command accepted on the first posedge after reset deassertion.
REQ-023 Since the bank resets synchronously, reset SHALL be held >=2 clock edges by the system; block behaviour is unaffected otherwise.

Configuration
REQ-024 Macro REG_BANK_MASTER_RDBACK_EN selects write readback.
REQ-025 With macro: WRITE -> VERIFY (seloutA=selwreg, cnstA=0, enrregA=1) -> CAPTURE -> RESP; every write returns a response with rsp_dataA = readback.
REQ-026 With macro: rsp_err=1 iff mode was 00 and readback != written data; modes 01/10/11 report rsp_err=0.
REQ-027 Without macro: writes produce no response, VERIFY absent, rsp_err tied 0.

Structure
REQ-028 Package reg_bank_pkg SHALL hold DATA_W=64, ADDR_W=4, op codes, endreg mode codes (00 both, 01/10 half, 11 swap), state enum.
REQ-029 Single FSM, no sub-module.

Verification
REQ-030 Write 24 to reg A mode 00, then write 25 to reg B -> regwen one-cycle pulses with selwreg A then B, inA 24 then 25.
REQ-031 Read op 11, raddrA=A, raddrB=B -> rsp_valid 3 cycles after accept, rsp_dataA=24, rsp_dataB=25.
REQ-032 Read op 01 with rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready 0 throughout, release on rsp_ready.
REQ-033 Assert reset during CAPTURE -> outputs 0 immediately, no rsp_valid; next read succeeds.
REQ-034 Macro on: write 0x0123456789ABCDEF to reg 3 mode 00 -> response rsp_dataA equal, rsp_err=0; mode 11 write -> rsp_err=0.
REQ-035 Read with cnstA=1 -> cnstA high during READ, rsp_dataA equals bank constant.
